// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type codes and the
// default word width. The RX parity checker imports the same package so
// both ends of the link agree on what "even" and "odd" mean.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator. Even parity is the XOR of the word,
// odd parity its inverse, matching the rule the receiver checks.
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_o
);

  assign par_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches a parallel word on Data_Valid and shifts it out
// LSB-first as start, data, optional parity and stop bit(s), each held for
// CLKS_PER_BIT clocks. TX_OUT and busy are registered.
// Build option: define UART_TX_STOP2_EN for two stop bits per frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  state_e                  state_q;
  logic [CW-1:0]           cyc_q;
  logic [BW-1:0]           bit_q;
  logic [DATA_WIDTH-1:0]   shadow_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    tx_q;
  logic                    busy_q;

  logic                    cyc_last;
  logic [BW-1:0]           bit_nxt;
  logic                    par_bit;

  assign cyc_last = (cyc_q == CYC_LAST);
  assign bit_nxt  = bit_q + 1'b1;
  assign TX_OUT   = tx_q;
  assign busy     = busy_q;

  // Parity is taken from the latched word and type, never the live inputs.
  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data_i    (shadow_q),
    .par_typ_i (par_typ_q),
    .par_o     (par_bit)
  );

  // Frame FSM: bit/cycle counters, shadow capture and registered line/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shadow_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (Data_Valid) begin
            shadow_q  <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            cyc_q     <= '0;
            bit_q     <= '0;
          end
        end
        START: begin
          if (cyc_last) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shadow_q[0];
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        DATA: begin
          if (cyc_last) begin
            cyc_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_nxt;
              tx_q  <= shadow_q[bit_nxt];
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        PARITY: begin
          if (cyc_last) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        STOP: begin
          if (cyc_last) begin
            cyc_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              // Last stop cycle doubles as the back-to-back acceptance window.
              if (Data_Valid) begin
                shadow_q  <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                state_q   <= START;
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
              end else begin
                state_q <= IDLE;
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_q <= bit_nxt;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a frame-level reference model expands every
// accepted request into the expected per-cycle {busy, TX_OUT} stream; a
// monitor pops one entry per cycle and compares against the DUT.
module tb_uart_tx;

  parameter int CPB = 1;
  localparam int DW = 8;

`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          busy;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  logic [1:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic       mon_en = 1'b0;
  logic [1:0] mon_exp;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: {busy,tx} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input logic pen);
    return (DW + 1 + STOP_BITS + int'(pen)) * CPB;
  endfunction

  // Reference model: a frame is start(0), data LSB first, optional parity, stop(1)s.
  task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic typ);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(typ ? ~(^d) : (^d));
    for (int s = 0; s < STOP_BITS; s++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < CPB; c++) exp_q.push_back({1'b1, bits[i]});
  endtask

  // A request is taken only when no expected line activity remains, i.e.
  // the transmitter is idle or finishing its final stop cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q.delete();
    else if (Data_Valid && exp_q.size() == 0) push_frame(P_DATA, PAR_EN, PAR_TYP);
  end

  // Monitor: one expected entry per cycle; idle line when nothing is pending.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b01;
      check("line", {busy, TX_OUT}, mon_exp);
    end
  end

  // Caller is at a negedge: hold Data_Valid for exactly one sampling edge.
  task automatic pulse(input logic [DW-1:0] d, input logic pen, input logic typ);
    P_DATA = d; PAR_EN = pen; PAR_TYP = typ; Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("drain_timeout", 2'b11, 2'b01);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset", {busy, TX_OUT}, 2'b01);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed frames: plain, even/odd parity on 0xA5 and 0x07.
    pulse(8'hA5, 1'b0, 1'b0); wait_idle();
    pulse(8'hA5, 1'b1, 1'b0); wait_idle();
    pulse(8'hA5, 1'b1, 1'b1); wait_idle();
    pulse(8'h07, 1'b1, 1'b0); wait_idle();
    pulse(8'h07, 1'b1, 1'b1); wait_idle();

    // Back-to-back: second request lands on the final stop cycle.
    pulse(8'h3C, 1'b0, 1'b0);
    repeat (frame_len(1'b0) - 1) @(negedge clk);
    pulse(8'hC3, 1'b0, 1'b0);
    wait_idle();

    // Mid-frame request and input changes must be ignored.
    pulse(8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    P_DATA = 8'hFF; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    @(negedge clk);
    Data_Valid = 1'b0; P_DATA = 8'h5A; PAR_EN = 1'b0;
    wait_idle();

    // Asynchronous reset during data bit 3.
    pulse(8'hA5, 1'b0, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async", {busy, TX_OUT}, 2'b01);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    pulse(8'h96, 1'b1, 1'b1);
    wait_idle();

    // Randomized requests, including requests while busy.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      Data_Valid = ($urandom_range(0, 7) == 0);
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
    end
    @(negedge clk);
    Data_Valid = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
